// File: rtl/sel_lu_arbiter_if.sv
// sel_lu_arbiter_if: client handshake, result and logic-unit bus of the two-client arbiter
interface sel_lu_arbiter_if #(parameter int WIDTH = 4);
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             op0, op1;
  logic             gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [WIDTH-1:0] lu_a, lu_b;
  logic             lu_chave;
  logic [WIDTH-1:0] lu_s;
  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, lu_s,
    output gnt0, gnt1, done0, done1, result, busy, lu_a, lu_b, lu_chave
  );
  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, lu_s,
    input  gnt0, gnt1, done0, done1, result, busy, lu_a, lu_b, lu_chave
  );
endinterface

// File: rtl/sel_lu_arbiter.sv
// sel_lu_arbiter: round-robin two-client sequencer for the shared AND/OR logic unit
// Optional per-client done counters enabled by SEL_ARB_OPCOUNT_EN.
module sel_lu_arbiter #(parameter int WIDTH = 4) (
  input logic clk,
  input logic reset,
  sel_lu_arbiter_if.slave bus
`ifdef SEL_ARB_OPCOUNT_EN
  ,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           state_q;
  logic             prio_q, own_q, win1;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, lu_chave_q;
  logic [WIDTH-1:0] result_q, lu_a_q, lu_b_q;
  // prio_q = 1 gives client 1 the win on contention
  assign win1 = bus.req1 & (~bus.req0 | prio_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      own_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      lu_a_q     <= '0;
      lu_b_q     <= '0;
      lu_chave_q <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req0 | bus.req1) begin
          state_q    <= EXEC;
          own_q      <= win1;
          prio_q     <= ~win1;
          gnt0_q     <= ~win1;
          gnt1_q     <= win1;
          lu_a_q     <= win1 ? bus.a1 : bus.a0;
          lu_b_q     <= win1 ? bus.b1 : bus.b0;
          lu_chave_q <= win1 ? bus.op1 : bus.op0;
        end
        EXEC: begin
          state_q  <= DONE;
          result_q <= bus.lu_s;
          done0_q  <= ~own_q;
          done1_q  <= own_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.result   = result_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.lu_a     = lu_a_q;
  assign bus.lu_b     = lu_b_q;
  assign bus.lu_chave = lu_chave_q;
`ifdef SEL_ARB_OPCOUNT_EN
  logic [7:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == EXEC) begin
      if (!own_q && cnt0_q != 8'hff) cnt0_q <= cnt0_q + 8'd1;
      if (own_q && cnt1_q != 8'hff) cnt1_q <= cnt1_q + 8'd1;
    end
  end
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_sel_lu_arbiter.sv
// tb_sel_lu_arbiter: directed checks of arbitration, latency, latching and reset abort
module tb_sel_lu_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  sel_lu_arbiter_if #(.WIDTH(4)) bus ();
`ifdef SEL_ARB_OPCOUNT_EN
  logic [7:0] cnt0, cnt1;
  sel_lu_arbiter #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave), .cnt0(cnt0), .cnt1(cnt1));
`else
  sel_lu_arbiter #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif
  // behavioural model of the external logic unit
  assign bus.lu_s = bus.lu_chave ? (bus.lu_a & bus.lu_b) : (bus.lu_a | bus.lu_b);
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
`ifdef SEL_ARB_OPCOUNT_EN
  task automatic run_op(input logic c);
    bus.req0 = ~c;
    bus.req1 = c;
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    step();
  endtask
`endif
  initial begin
    reset = 1'b1;
    {bus.req0, bus.req1, bus.op0, bus.op1} = '0;
    {bus.a0, bus.b0, bus.a1, bus.b1} = '0;
    step();
    step();
    chk("rst_gnt", 8'({bus.gnt0, bus.gnt1}), 8'd0);
    chk("rst_done", 8'({bus.done0, bus.done1}), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_result", 8'(bus.result), 8'd0);
    chk("rst_lu", 8'({bus.lu_chave, bus.lu_a, bus.lu_b}), 8'd0);
    reset = 1'b0;
    // client 0 alone, AND
    bus.req0 = 1'b1; bus.a0 = 4'b0101; bus.b0 = 4'b1010; bus.op0 = 1'b1;
    step();
    chk("t1_gnt", 8'({bus.gnt0, bus.gnt1}), 8'b10);
    chk("t1_done_early", 8'({bus.done0, bus.done1}), 8'd0);
    chk("t1_busy", 8'(bus.busy), 8'd1);
    chk("t1_lu", 8'({bus.lu_chave, bus.lu_a}), 8'b1_0101);
    chk("t1_lub", 8'(bus.lu_b), 8'b1010);
    bus.req0 = 1'b0;
    step();
    chk("t1_done", 8'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 8'b0010);
    chk("t1_result", 8'(bus.result), 8'b0000);
    step();
    chk("t1_idle", 8'({bus.busy, bus.done0}), 8'd0);
    // client 1 alone, OR
    bus.req1 = 1'b1; bus.a1 = 4'b0101; bus.b1 = 4'b1010; bus.op1 = 1'b0;
    step();
    chk("t2_gnt", 8'({bus.gnt0, bus.gnt1}), 8'b01);
    bus.req1 = 1'b0;
    step();
    chk("t2_done", 8'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 8'b0001);
    chk("t2_result", 8'(bus.result), 8'b1111);
    step();
    chk("t2_idle", 8'(bus.busy), 8'd0);
    // contention: grants must alternate starting with client 0
    bus.a0 = 4'b1111; bus.b0 = 4'b0000; bus.op0 = 1'b0;
    bus.a1 = 4'b1001; bus.b1 = 4'b1000; bus.op1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_gnt%0d", i), 8'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), (i % 2 == 0) ? 8'b1000 : 8'b0100);
      step();
      chk($sformatf("t3_done%0d", i), 8'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), (i % 2 == 0) ? 8'b0010 : 8'b0001);
      chk($sformatf("t3_res%0d", i), 8'(bus.result), (i % 2 == 0) ? 8'b1111 : 8'b1000);
      step();
      chk($sformatf("t3_idle%0d", i), 8'({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 8'd0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    // operands change after grant; latched copy must be used
    bus.req0 = 1'b1; bus.a0 = 4'b1111; bus.b0 = 4'b1111; bus.op0 = 1'b1;
    step();
    chk("t4_gnt", 8'(bus.gnt0), 8'd1);
    bus.a0 = 4'b0000; bus.req0 = 1'b0;
    #1;
    chk("t4_lua_exec", 8'(bus.lu_a), 8'b1111);
    step();
    chk("t4_done", 8'(bus.done0), 8'd1);
    chk("t4_result", 8'(bus.result), 8'b1111);
    chk("t4_lua_hold", 8'(bus.lu_a), 8'b1111);
    step();
    // reset in EXEC after a client-0 grant (prio now points to client 1)
    bus.req0 = 1'b1; bus.a0 = 4'b0011; bus.b0 = 4'b0101; bus.op0 = 1'b0;
    step();
    chk("t5_gnt", 8'(bus.gnt0), 8'd1);
    reset = 1'b1; bus.req0 = 1'b0;
    step();
    chk("t5_busy", 8'(bus.busy), 8'd0);
    chk("t5_done", 8'({bus.done0, bus.done1}), 8'd0);
    chk("t5_result", 8'(bus.result), 8'd0);
    chk("t5_lu", 8'({bus.lu_chave, bus.lu_a, bus.lu_b}), 8'd0);
    reset = 1'b0;
    step();
    chk("t5_no_done", 8'({bus.done0, bus.done1, bus.busy}), 8'd0);
    // prio cleared by reset: dual request goes to client 0
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    chk("t5_prio", 8'({bus.gnt0, bus.gnt1}), 8'b10);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    chk("t5_done0", 8'({bus.done0, bus.done1}), 8'b10);
    chk("t5_result2", 8'(bus.result), 8'b0111);
    step();
`ifdef SEL_ARB_OPCOUNT_EN
    run_op(1'b0);
    run_op(1'b0);
    run_op(1'b1);
    chk("cnt0_3", cnt0, 8'd3);
    chk("cnt1_1", cnt1, 8'd1);
    for (int i = 0; i < 257; i++) run_op(1'b0);
    chk("cnt0_sat", cnt0, 8'd255);
    chk("cnt1_keep", cnt1, 8'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
